// File: rtl/fifo_fwft_pkg.sv
// Shared types and sizing helpers for the fwft level FIFO.
// Optional high-water-mark output is enabled with FIFO_FWFT_HWM_EN.
package fifo_fwft_pkg;

    // Occupancy runs 0..2**aw inclusive, so it needs one bit more than the address.
    function automatic int unsigned cnt_width(input int unsigned aw);
        return aw + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: synchronous write port, asynchronous read port.
// Contents are not reset.
module dp_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_fwft_level_ctrl.sv
// Pointer, occupancy, threshold and sticky-error control for fifo_fwft_level.
// FIFO_FWFT_HWM_EN adds the high-water-mark register and its hwm output.
module fifo_fwft_level_ctrl
    import fifo_fwft_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    localparam int unsigned CW = cnt_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rs,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [CW-1:0]         count,
    output fifo_status_t          status
`ifdef FIFO_FWFT_HWM_EN
    ,
    output logic [CW-1:0]         hwm
`endif
);

    localparam logic [CW-1:0] DEPTH = CW'(2**ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  is_full, is_empty;
    logic                  wr_acc, rd_acc;
    logic                  ovf_set, udf_set;

    assign is_full  = (cnt_q == DEPTH);
    assign is_empty = (cnt_q == '0);

    // A flush cycle swallows wr/rd entirely, including their error side effects.
    always_comb begin
        wr_acc  = wr & (~is_full | rd) & ~flush;
        rd_acc  = rd & ~is_empty & ~flush;
        ovf_set = wr & is_full & ~rd & ~flush;
        udf_set = rd & is_empty & ~flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        udf_d = udf_set | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef FIFO_FWFT_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (flush) begin
            hwm_d = '0;
        end else if (cnt_d > hwm_q) begin
            hwm_d = cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

    assign wr_en   = wr_acc;
    assign wr_addr = wr_ptr_q;
    assign rd_addr = rd_ptr_q;
    assign count   = cnt_q;

    // Thresholds are live inputs compared against the registered count.
    always_comb begin
        status.full         = is_full;
        status.empty        = is_empty;
        status.almost_full  = (cnt_q >= af_thresh);
        status.almost_empty = (cnt_q <= ae_thresh);
        status.overflow     = ovf_q;
        status.underflow    = udf_q;
    end

endmodule

// File: rtl/fifo_fwft_level.sv
// First-word-fall-through FIFO with occupancy, thresholds, flush and sticky errors.
// Define FIFO_FWFT_HWM_EN to add the hwm (high-water mark) output.
module fifo_fwft_level
    import fifo_fwft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    localparam int unsigned CW = cnt_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rs,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_FWFT_HWM_EN
    ,
    output logic [CW-1:0]         hwm
`endif
);

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    fifo_status_t          status;

    fifo_fwft_level_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk       (clk),
        .rs        (rs),
        .wr        (wr),
        .rd        (rd),
        .flush     (flush),
        .clr_err   (clr_err),
        .af_thresh (af_thresh),
        .ae_thresh (ae_thresh),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .count     (count),
        .status    (status)
`ifdef FIFO_FWFT_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    // Asynchronous read keeps the head word visible without a pipeline bubble.
    dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

endmodule

// File: tb/tb_fifo_fwft_level.sv
// Bench for fifo_fwft_level (depth 4): vector table, corner sequences, random vs queue model.
// hwm checks are compiled in when FIFO_FWFT_HWM_EN is defined.
module tb_fifo_fwft_level;

    logic       clk = 1'b0;
    logic       rs;
    logic       wr, rd, flush, clr_err;
    logic [7:0] wr_data;
    logic [2:0] af_thresh, ae_thresh;
    logic [7:0] rd_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;
`ifdef FIFO_FWFT_HWM_EN
    logic [2:0] hwm;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fifo_fwft_level #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (2)
    ) dut (
        .clk          (clk),
        .rs           (rs),
        .wr           (wr),
        .wr_data      (wr_data),
        .rd           (rd),
        .flush        (flush),
        .clr_err      (clr_err),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_FWFT_HWM_EN
        ,
        .hwm          (hwm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       fl;
        logic       clr;
        logic [2:0] af;
        logic [2:0] ae;
        logic [2:0] cnt;
        logic [5:0] flags;  // {full, empty, almost_full, almost_empty, overflow, underflow}
        logic       chk_rd;
        logic [7:0] rdd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int w, int d, int r, int f, int c, int af, int ae,
                                int cnt, int flags, int chk, int rdd);
        vec_t v;
        v.wr = w[0];   v.wd = d[7:0];  v.rd = r[0];  v.fl = f[0];  v.clr = c[0];
        v.af = af[2:0]; v.ae = ae[2:0]; v.cnt = cnt[2:0]; v.flags = flags[5:0];
        v.chk_rd = chk[0]; v.rdd = rdd[7:0];
        return v;
    endfunction

    // Reference model: contents as a queue, flags derived from its size.
    logic [7:0] q[$];
    bit         m_ovf, m_udf;
    int         m_hwm;

    function automatic void model_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_hwm = 0;
    endfunction

    function automatic void model_step(bit w, logic [7:0] d, bit r, bit f, bit c);
        int n = q.size();
        bit so = w && (n == 4) && !r && !f;
        bit su = r && (n == 0) && !f;
        if (f) begin
            q.delete();
        end else begin
            bit pop  = r && (n > 0);
            bit push = w && ((n < 4) || r);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        m_ovf = so || (m_ovf && !c);
        m_udf = su || (m_udf && !c);
        if (f) m_hwm = 0;
        else if (q.size() > m_hwm) m_hwm = q.size();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_flags();
        return {full, empty, almost_full, almost_empty, overflow, underflow};
    endfunction

    task automatic model_check(input string tag);
        int n = q.size();
        logic [5:0] exp_flags;
        exp_flags = {n == 4, n == 0, n >= int'(af_thresh), n <= int'(ae_thresh), m_ovf, m_udf};
        check({tag, " count"}, 32'(count), 32'(n));
        check({tag, " flags"}, 32'(dut_flags()), 32'(exp_flags));
        if (n > 0) check({tag, " rd_data"}, 32'(rd_data), 32'(q[0]));
`ifdef FIFO_FWFT_HWM_EN
        check({tag, " hwm"}, 32'(hwm), 32'(m_hwm));
`endif
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
        wr = w; wr_data = d; rd = r; flush = f; clr_err = c;
        model_step(w, d, r, f, c);
        @(posedge clk);
        #1;
        wr = 0; rd = 0; flush = 0; clr_err = 0;
    endtask

    initial begin
        rs = 1'b0; wr = 0; rd = 0; flush = 0; clr_err = 0; wr_data = '0;
        af_thresh = 3'd0; ae_thresh = 3'd0;
        model_reset();

        #12;
        check("reset count", 32'(count), 32'd0);
        check("reset flags af=0", 32'(dut_flags()), 32'(6'b011100));
        af_thresh = 3'd3; ae_thresh = 3'd1;
        #1;
        check("reset flags af=3", 32'(dut_flags()), 32'(6'b010100));
        @(negedge clk);
        rs = 1'b1;
        @(posedge clk);
        #1;

        // wr wd rd fl clr af ae | cnt flags chk rdd
        tbl.push_back(mk(1, 'hA5, 0, 0, 0, 3, 1, 1, 'b000100, 1, 'hA5));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 0, 'b010100, 0, 0));
        tbl.push_back(mk(1, 'h01, 0, 0, 0, 3, 1, 1, 'b000100, 1, 'h01));
        tbl.push_back(mk(1, 'h02, 0, 0, 0, 3, 1, 2, 'b000000, 1, 'h01));
        tbl.push_back(mk(1, 'h03, 0, 0, 0, 3, 1, 3, 'b001000, 1, 'h01));
        tbl.push_back(mk(1, 'h04, 0, 0, 0, 3, 1, 4, 'b101000, 1, 'h01));
        tbl.push_back(mk(1, 'h05, 0, 0, 0, 3, 1, 4, 'b101010, 1, 'h01));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 3, 'b001010, 1, 'h02));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 2, 'b000010, 1, 'h03));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 1, 'b000110, 1, 'h04));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 0, 'b010110, 0, 0));
        tbl.push_back(mk(1, 'h01, 0, 0, 0, 3, 1, 1, 'b000110, 1, 'h01));
        tbl.push_back(mk(1, 'h02, 0, 0, 0, 3, 1, 2, 'b000010, 1, 'h01));
        tbl.push_back(mk(1, 'h03, 0, 0, 0, 3, 1, 3, 'b001010, 1, 'h01));
        tbl.push_back(mk(1, 'h04, 0, 0, 0, 3, 1, 4, 'b101010, 1, 'h01));
        tbl.push_back(mk(1, 'h10, 1, 0, 0, 3, 1, 4, 'b101010, 1, 'h02));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 3, 'b001010, 1, 'h03));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 2, 'b000010, 1, 'h04));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 1, 'b000110, 1, 'h10));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 0, 'b010110, 0, 0));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 0, 'b010111, 0, 0));
        tbl.push_back(mk(0, 0,    1, 0, 1, 3, 1, 0, 'b010101, 0, 0));
        tbl.push_back(mk(0, 0,    0, 0, 1, 3, 1, 0, 'b010100, 0, 0));
        tbl.push_back(mk(1, 'h21, 0, 0, 0, 3, 1, 1, 'b000100, 1, 'h21));
        tbl.push_back(mk(1, 'h22, 0, 0, 0, 3, 1, 2, 'b000000, 1, 'h21));
        tbl.push_back(mk(1, 'h23, 0, 0, 0, 3, 1, 3, 'b001000, 1, 'h21));
        tbl.push_back(mk(1, 'h24, 0, 0, 0, 3, 1, 4, 'b101000, 1, 'h21));
        tbl.push_back(mk(1, 'h25, 0, 0, 0, 3, 1, 4, 'b101010, 1, 'h21));
        tbl.push_back(mk(0, 0,    1, 0, 0, 3, 1, 3, 'b001010, 1, 'h22));
        tbl.push_back(mk(1, 'h26, 0, 1, 0, 3, 1, 0, 'b010110, 0, 0));
        tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0, 0, 'b011110, 0, 0));
        tbl.push_back(mk(1, 'h30, 0, 0, 0, 5, 0, 1, 'b000010, 1, 'h30));
        tbl.push_back(mk(1, 'h31, 1, 0, 0, 5, 7, 1, 'b000110, 1, 'h31));

        foreach (tbl[i]) begin
            af_thresh = tbl[i].af;
            ae_thresh = tbl[i].ae;
            step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].fl, tbl[i].clr);
            check($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d flags", i), 32'(dut_flags()), 32'(tbl[i].flags));
            if (tbl[i].chk_rd)
                check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(tbl[i].rdd));
        end

        // Empty with wr and rd together: write lands, underflow flagged.
        af_thresh = 3'd3; ae_thresh = 3'd1;
        step(0, 0, 0, 1, 1);
        step(1, 8'h55, 1, 0, 0);
        check("empty wr+rd count", 32'(count), 32'd1);
        check("empty wr+rd underflow", 32'(underflow), 32'd1);
        check("empty wr+rd rd_data", 32'(rd_data), 32'h55);
        step(0, 0, 0, 0, 1);

`ifdef FIFO_FWFT_HWM_EN
        step(0, 0, 0, 1, 0);
        check("hwm after flush", 32'(hwm), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 8'h70, 0, 0, 0);
        check("hwm peak", 32'(hwm), 32'd3);
        check("hwm count", 32'(count), 32'd2);
        step(0, 0, 0, 1, 0);
        check("hwm flushed", 32'(hwm), 32'd0);
`endif

        // Asynchronous reset mid-transfer: no clock edge needed.
        step(1, 8'h81, 0, 0, 0);
        wr = 1; wr_data = 8'h82;
        #2;
        rs = 1'b0;
        #1;
        check("async reset count", 32'(count), 32'd0);
        check("async reset empty", 32'(empty), 32'd1);
        wr = 0;
        model_reset();
        @(negedge clk);
        rs = 1'b1;
        @(posedge clk);
        #1;
        model_check("post-reset");

        for (int i = 0; i < 3000; i++) begin
            int  wp = (i / 250) % 2 ? 75 : 35;
            bit  w  = $urandom_range(0, 99) < wp;
            bit  r  = $urandom_range(0, 99) < (110 - wp);
            bit  f  = $urandom_range(0, 63) == 0;
            bit  c  = $urandom_range(0, 15) == 0;
            logic [7:0] d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                af_thresh = 3'($urandom_range(0, 7));
                ae_thresh = 3'($urandom_range(0, 7));
            end
            step(w, d, r, f, c);
            model_check($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_fwft_level.md
Name: fifo_fwft_level

Overview:
- Parametrised first-word-fall-through FIFO for the range-sensor control path: buffers echo/range samples between capture logic and the bus-side reader.
- Head word is always visible on rd_data while not empty; rd pops it.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, read-while-full pass-through, synchronous flush and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, address width; depth is 2**ADDR_WIDTH words.

Ports:
- clk  in  1  clock, rising edge.
- rs  in  1  asynchronous reset, active-low.
- wr  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd  in  1  pop request for the head word.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  clears sticky error flags.
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold.
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold.
- rd_data  out  DATA_WIDTH  head word; valid only when empty=0.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- count  out  ADDR_WIDTH+1  current occupancy, 0..depth.
- overflow  out  1  sticky: write dropped.
- underflow  out  1  sticky: pop on empty.

Behaviour:
- Reset (rs=0, async): pointers=0, count=0, empty=1, full=0, almost_empty=1 (ae_thresh>=0 always), almost_full=(af_thresh==0), overflow=0, underflow=0. Storage contents are not reset. rd_data is don't-care while empty.
- Accept rules:
  - wr_acc = wr & (~full | rd).
  - rd_acc = rd & ~empty.
  - Full with rd=1 and wr=1: both accepted in the same cycle; count unchanged.
  - Empty with wr=1 and rd=1: only the write is accepted; underflow is set.
- Latency: a word written into an empty FIFO appears on rd_data and deasserts empty on the next rising edge. The read path is combinational from the head address; no extra bubble.
- Count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Flags derive from the registered count/pointer state; no combinational path from wr/rd to the flags.
- Pointers wrap modulo depth. full/empty come from count, not from pointer comparison.
- overflow sets on wr & full & ~rd. underflow sets on rd & empty. Both stay set until clr_err=1 for one cycle. A set event in the same cycle as clr_err wins, so the flag stays 1.
- flush=1: next edge sets pointers=0 and count=0. Any wr/rd in the same cycle is ignored. Error flags are unaffected.
- Thresholds are compared unsigned against count. af_thresh > depth means almost_full never asserts. Thresholds may change any cycle; flags follow on the same cycle (combinational compare against registered count).
- Reset asserted mid-transfer discards all contents immediately.

Optional Feature:
- Macro FIFO_FWFT_HWM_EN.
- When defined: adds output hwm (ADDR_WIDTH+1), the high-water mark of count since reset or flush.
  - Updated each cycle to max(hwm, next count).
  - Cleared by reset and flush.
- When undefined: no hwm port and no associated logic. All other behaviour is identical.

Decomposition:
- Package fifo_fwft_pkg holds:
  - the function computing count width from ADDR_WIDTH;
  - a typedef for the status bundle (full, empty, almost_full, almost_empty, overflow, underflow) for upstream registers.
- Natural sub-module: fifo_fwft_level_ctrl, which holds pointers, count, flags and sticky errors.
- Storage uses the team's existing dual-port ram module (synchronous write, asynchronous read).

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=2, depth 4):
- Reset then write 0xA5 once → next cycle empty=0, rd_data=0xA5, count=1. rd one cycle → empty=1, count=0.
- Write 0x01..0x04 → full=1, count=4. Write 0x05 with rd=0 → overflow=1, count=4. Pop all → reads 0x01,0x02,0x03,0x04 in order.
- Full FIFO, rd=1 and wr=1 with 0x10 → count stays 4. 0x10 emerges as the 4th subsequent pop after the in-flight pop of 0x01 (pointer wrap exercised).
- Empty, rd=1 → underflow=1. Same cycle clr_err=1 with rd=1 → underflow stays 1. Next cycle clr_err=1 alone → underflow=0.
- af_thresh=3, ae_thresh=1: count 0→1 gives almost_empty=1; count 2 gives both flags 0; count 3 gives almost_full=1. flush at count 3 → count=0, empty=1, overflow unchanged.
- With FIFO_FWFT_HWM_EN: write 3, pop 2, write 1 → hwm=3. flush → hwm=0. Async reset during writes → count=0 immediately, without waiting for a clock edge.
